// File: rtl/dram_pkg.sv
// Shared types and sizing for the bank reader: FSM states, default geometry,
// and the parameter legality rule used at elaboration.
package dram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int IO_WIDTH_DEF   = 16;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int RD_LATENCY_DEF = 0;

    localparam int NWORDS     = (2 ** ADDR_WIDTH_DEF) / IO_WIDTH_DEF;
    localparam int BIT_IDX_W  = $clog2(IO_WIDTH_DEF);
    localparam int WORD_IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    // IO_WIDTH must be a power of two of at least 2 that fits inside one bank.
    function automatic bit params_ok(input int io_w, input int addr_w, input int lat);
        return (addr_w >= 1) && (io_w >= 2) && ((io_w & (io_w - 1)) == 0) &&
               (io_w <= (2 ** addr_w)) && (lat == 0 || lat == 1);
    endfunction

endpackage

// File: rtl/dram_bit_packer.sv
// Serial-in/parallel-out word assembler; absorbs the RAM read latency by
// delaying the sample strobe and bit index alongside the returning data.
module dram_bit_packer
    import dram_pkg::*;
#(
    parameter int IO_WIDTH   = IO_WIDTH_DEF,
    parameter int IDX_W      = $clog2(IO_WIDTH_DEF),
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [IDX_W-1:0]    bit_idx,
    input  logic                rd_data,
    output logic [IO_WIDTH-1:0] word_data,
    output logic                word_complete
);

    logic             en_eff;
    logic [IDX_W-1:0] idx_eff;
    logic [IO_WIDTH-1:0] shreg, shreg_n;

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            logic             en_q;
            logic [IDX_W-1:0] idx_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_q  <= 1'b0;
                    idx_q <= '0;
                end else begin
                    en_q  <= sample_en;
                    idx_q <= bit_idx;
                end
            end
            assign en_eff  = en_q;
            assign idx_eff = idx_q;
        end else begin : g_lat0
            assign en_eff  = sample_en;
            assign idx_eff = bit_idx;
        end
    endgenerate

    always_comb begin
        shreg_n = shreg;
        if (en_eff) shreg_n[idx_eff] = rd_data;
    end

    assign word_complete = en_eff && (idx_eff == IDX_W'(IO_WIDTH - 1));

    // word_data only changes on completion so it stays stable through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            word_data <= '0;
        end else begin
            shreg <= shreg_n;
            if (word_complete) word_data <= shreg_n;
        end
    end

endmodule

// File: rtl/dram_bank_reader.sv
// Walks one bank of a bit-wide dual-port RAM through its read port and hands
// the bits out as IO_WIDTH-wide words over valid/ready.
module dram_bank_reader
    import dram_pkg::*;
#(
    parameter int IO_WIDTH   = IO_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bank,
    output logic                  busy,
    output logic                  rd_bank,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_data,
    output logic [IO_WIDTH-1:0]   word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  done
);

    localparam int IDX_W = $clog2(IO_WIDTH);

    generate
        if (!params_ok(IO_WIDTH, ADDR_WIDTH, RD_LATENCY)) begin : g_bad_params
            $error("dram_bank_reader: illegal IO_WIDTH/ADDR_WIDTH/RD_LATENCY");
        end
    endgenerate

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] rd_addr_n;
    logic                  rd_bank_n;
    logic                  word_valid_n;
    logic                  issue_done, issue_done_n;
    logic                  sample_en;
    logic                  word_complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_addr    <= '0;
            rd_bank    <= 1'b0;
            word_valid <= 1'b0;
            issue_done <= 1'b0;
        end else begin
            state      <= state_n;
            rd_addr    <= rd_addr_n;
            rd_bank    <= rd_bank_n;
            word_valid <= word_valid_n;
            issue_done <= issue_done_n;
        end
    end

    // The address only advances on issued reads, so after a word it already
    // points at the next word's first bit; with RD_LATENCY=1 the final FILL
    // cycle re-reads that address and the packer ignores it.
    always_comb begin
        state_n      = state;
        rd_addr_n    = rd_addr;
        rd_bank_n    = rd_bank;
        word_valid_n = word_valid;
        issue_done_n = issue_done;
        sample_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = FILL;
                    rd_bank_n    = bank;
                    rd_addr_n    = '0;
                    issue_done_n = 1'b0;
                end
            end
            FILL: begin
                sample_en = !issue_done;
                if (sample_en) begin
                    rd_addr_n = rd_addr + 1'b1;
                    if (rd_addr[IDX_W-1:0] == IDX_W'(IO_WIDTH - 1)) issue_done_n = 1'b1;
                end
                if (word_complete) begin
                    word_valid_n = 1'b1;
                    state_n      = HOLD;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    word_valid_n = 1'b0;
                    issue_done_n = 1'b0;
                    // Address wrapped to 0 means the word just taken was the last.
                    state_n      = (rd_addr == '0) ? DONE : FILL;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    dram_bit_packer #(
        .IO_WIDTH  (IO_WIDTH),
        .IDX_W     (IDX_W),
        .RD_LATENCY(RD_LATENCY)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .bit_idx      (rd_addr[IDX_W-1:0]),
        .rd_data      (rd_data),
        .word_data    (word_data),
        .word_complete(word_complete)
    );

endmodule

// File: tb/tb_dram_bank_reader.sv
// Directed bench: one reader on an async-read RAM model, one on a
// registered-read RAM model, sharing clock, reset, bank and word_ready.
module tb_dram_bank_reader;

    localparam logic [63:0] BANK0 = 64'h96A5_96A5_96A5_96A5;
    localparam logic [63:0] BANK1 = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        bank = 1'b0;
    logic        word_ready = 1'b0;

    logic        busy0, rd_bank0, word_valid0, done0, rd_data0;
    logic [5:0]  rd_addr0;
    logic [15:0] word_data0;
    logic        busy1, rd_bank1, word_valid1, done1, rd_data1;
    logic [5:0]  rd_addr1;
    logic [15:0] word_data1;

    logic [127:0] mem;
    assign mem = {BANK1, BANK0};

    always #5 clk = ~clk;

    assign rd_data0 = mem[{rd_bank0, rd_addr0}];
    always @(posedge clk) rd_data1 <= mem[{rd_bank1, rd_addr1}];

    dram_bank_reader #(.IO_WIDTH(16), .ADDR_WIDTH(6), .RD_LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bank(bank), .busy(busy0),
        .rd_bank(rd_bank0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .word_data(word_data0), .word_valid(word_valid0), .word_ready(word_ready),
        .done(done0)
    );

    dram_bank_reader #(.IO_WIDTH(16), .ADDR_WIDTH(6), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bank(bank), .busy(busy1),
        .rd_bank(rd_bank1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .word_data(word_data1), .word_valid(word_valid1), .word_ready(word_ready),
        .done(done1)
    );

    // Handshake and done-pulse counters for the selected reader.
    int hs0 = 0, hs1 = 0, dn0 = 0, dn1 = 0;
    always @(posedge clk) begin
        if (word_valid0 && word_ready) hs0++;
        if (word_valid1 && word_ready) hs1++;
        if (done0) dn0++;
        if (done1) dn1++;
    end

    logic        sel = 1'b0;
    logic        v, dn, bz, rb;
    logic [15:0] wd;
    always_comb begin
        v  = sel ? word_valid1 : word_valid0;
        wd = sel ? word_data1  : word_data0;
        dn = sel ? done1       : done0;
        bz = sel ? busy1       : busy0;
        rb = sel ? rd_bank1    : rd_bank0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic val);
        if (sel) start1 = val;
        else     start0 = val;
    endtask

    // Called at a negedge; returns at the negedge of FILL cycle 0.
    task automatic kick(input logic b);
        bank = b;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        chk("busy_after_start", bz, 1'b1);
        chk("rd_bank_latched", rb, b);
    endtask

    task automatic collect(input int first_fill, input int fill, input int stall,
                           input bit pulse_hold, input bit pulse_done,
                           input logic [63:0] exp_bank, input logic exp_rb);
        int          cnt;
        logic [15:0] held;
        int          hs_start, dn_start;
        hs_start = sel ? hs1 : hs0;
        dn_start = sel ? dn1 : dn0;
        for (int w = 0; w < 4; w++) begin
            cnt = 0;
            while (!v && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk("fill_cycles", cnt, (w == 0) ? first_fill : fill);
            chk("word_data", wd, exp_bank[w*16 +: 16]);
            chk("rd_bank_hold", rb, exp_rb);
            held = wd;
            if (stall > 0) begin
                word_ready = 1'b0;
                for (int i = 0; i < stall; i++) begin
                    if (pulse_hold && i == 1) begin
                        bank = ~bank;
                        set_start(1'b1);
                    end
                    @(negedge clk);
                    set_start(1'b0);
                    chk("stall_valid", v, 1'b1);
                    chk("stall_stable", wd, held);
                end
                word_ready = 1'b1;
            end
            @(negedge clk);
            chk("valid_drop", v, 1'b0);
        end
        chk("done_pulse", dn, 1'b1);
        chk("busy_in_done", bz, 1'b1);
        if (pulse_done) set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        chk("done_clear", dn, 1'b0);
        chk("busy_clear", bz, 1'b0);
        @(negedge clk);
        chk("idle_stays", bz, 1'b0);
        chk("handshakes", (sel ? hs1 : hs0) - hs_start, 4);
        chk("done_count", (sel ? dn1 : dn0) - dn_start, 1);
    endtask

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outs0", {busy0, rd_bank0, rd_addr0, word_data0, word_valid0, done0}, '0);
            chk("idle_outs1", {busy1, rd_bank1, rd_addr1, word_data1, word_valid1, done1}, '0);
        end

        // Pattern dump, async read, bank 1, ready held high
        sel = 1'b0;
        word_ready = 1'b1;
        kick(1'b1);
        collect(16, 16, 0, 1'b0, 1'b0, BANK1, 1'b1);

        // Backpressure, bank 0
        kick(1'b0);
        collect(16, 16, 5, 1'b0, 1'b0, BANK0, 1'b0);

        // Registered-read RAM, bank 1
        sel = 1'b1;
        kick(1'b1);
        collect(17, 17, 0, 1'b0, 1'b0, BANK1, 1'b1);

        // Ignored start and bank toggles during FILL, HOLD and DONE
        sel = 1'b0;
        kick(1'b1);
        repeat (3) @(negedge clk);
        bank = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("rd_bank_fill_toggle", rd_bank0, 1'b1);
        collect(12, 16, 3, 1'b1, 1'b1, BANK1, 1'b1);

        // Reset during word 2 FILL
        kick(1'b1);
        repeat (39) @(negedge clk);
        chk("mid_dump_busy", busy0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy0, 1'b0);
        chk("async_rst_addr", rd_addr0, 6'd0);
        chk("async_rst_word", {word_data0, word_valid0, done0, rd_bank0}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {busy0, word_valid0, done0}, 3'b000);
        kick(1'b1);
        collect(16, 16, 0, 1'b0, 1'b0, BANK1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
